usb_ccw_arb_ctrl: RTL and testbench
===================================

USB_CCW_ARB_CTRL -- requirements
Module: usb_ccw_arb_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of CCW channels (2..16).
REQ-002 Parameter CNT_W, default 4: pending-CCW counter width per channel.
REQ-003 Parameter TO_CYC, default 255: read-acknowledge timeout in clk_prj cycles.
REQ-004 clk_prj  in  1  project clock; all logic SHALL be clocked on its rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 ccw_accepted  in  NCH  per-channel one-cycle pulse: one new CCW written to that channel buffer.
REQ-007 ccw_repeat_req  in  NCH  per-channel one-cycle pulse: replay one CCW.
REQ-008 ccwb_is_read  in  NCH  per-channel one-cycle pulse: channel buffer read complete.
REQ-009 ccw_rx_rdy  in  1  host-side ready level, asynchronous to clk_prj.
REQ-010 err_clr  in  1  one-cycle pulse clearing sticky error flags.
REQ-011 ccwb_rdreq  out  NCH  one-hot, one-cycle read request to the granted channel buffer.
REQ-012 ccw_ch_sel  out  $clog2(NCH)  index of the granted channel, held from grant until return to IDLE.
REQ-013 ccw_tx_rdy  out  1  any channel pending OR synchronised rx_rdy.
REQ-014 busy  out  1  high when FSM is not IDLE.
REQ-015 timeout_err  out  1  sticky: read acknowledge not received within TO_CYC.
REQ-016 ovf_err  out  NCH  sticky per-channel pending-counter saturation.

Function
REQ-017 ccw_rx_rdy SHALL pass through a 2-FF synchroniser; rising edge of the synchronised level SHALL form rx_evt (one cycle).
REQ-018 Per channel, pending count: +1 per accepted, +1 per repeat_req, -1 per is_read on the granted channel; all in the same cycle SHALL net arithmetically.
REQ-019 Counter SHALL saturate at 2^CNT_W-1 and set ovf_err[ch]; it SHALL never wrap below 0 (is_read at zero ignored).
REQ-020 FSM states: IDLE, GRANT, WAIT_RD.
REQ-021 IDLE->GRANT when (rx_evt or evt_pend) and any count>0; winner chosen round-robin starting at last_grant+1 modulo NCH.
REQ-022 GRANT SHALL last exactly one cycle and assert ccwb_rdreq[winner]; latency rx_evt to rdreq = 1 cycle.
REQ-023 GRANT->WAIT_RD unconditionally; WAIT_RD->IDLE on ccwb_is_read[ccw_ch_sel], updating last_grant.
REQ-024 WAIT_RD timeout counter SHALL count from 0; on reaching TO_CYC without acknowledge: set timeout_err, leave count unchanged, go IDLE.
REQ-025 rx_evt arriving outside IDLE SHALL set one-deep evt_pend; cleared when consumed by a grant; further events while set are dropped.
REQ-026 rx_evt in IDLE with all counts zero SHALL be discarded.
REQ-027 ccwb_is_read on a non-granted channel SHALL be ignored.
REQ-028 err_clr SHALL clear timeout_err and ovf_err; a simultaneous set SHALL win.
REQ-029 ccw_tx_rdy SHALL be combinational OR of (any count>0) and synchronised rx_rdy.

Reset
REQ-030 On n_rst low: FSM IDLE, all counts 0, last_grant = NCH-1 (channel 0 first), evt_pend 0, synchroniser 0, ccwb_rdreq 0, ccw_ch_sel 0, busy 0, errors 0.
REQ-031 Reset mid-WAIT_RD SHALL abandon the transaction with no pending state retained.

Structure
REQ-032 Shared package usb_ccw_pkg SHALL hold the FSM state enum and default NCH/CNT_W/TO_CYC constants.
REQ-033 Round-robin arbiter SHALL be a sub-module usb_rr_arb (request vector, last-grant in, one-hot grant out), combinational.
REQ-034 Per-channel counters SHALL be a generate loop inside the top module.

Verification
REQ-035 Ch1 accepted x2, rx_rdy rises -> rdreq=0010 at 3 cycles after sync edge, ch_sel=1; is_read[1] -> count[1]=1, IDLE.
REQ-036 Counts {1,1,1,1}, four rx edges each acknowledged -> grant order 0,1,2,3; fifth edge discarded.
REQ-037 Grant ch2, no is_read for 255 cycles -> timeout_err=1, count[2] unchanged, busy=0; err_clr -> timeout_err=0.
REQ-038 CNT_W=4, 16 accepted on ch0 -> count=15, ovf_err[0]=1; is_read with accepted same cycle -> count stays 15.
REQ-039 Two rx edges during WAIT_RD -> exactly one further grant after acknowledge.
REQ-040 n_rst asserted in WAIT_RD -> all outputs at reset values within same cycle; grant order restarts at channel 0.

Source files
------------

// File: rtl/usb_ccw_pkg.sv
// ============================================================
// usb_ccw_pkg : shared constants and FSM encoding for CCW arbitration
// Rev 1.0
// ============================================================
`default_nettype none

package usb_ccw_pkg;

   localparam int DEF_NCH    = 4;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_TO_CYC = 255;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_WAIT_RD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/usb_rr_arb.sv
// ============================================================
// usb_rr_arb : combinational round-robin arbiter, search starts at last+1
// Rev 1.0
// ============================================================
`default_nettype none

module usb_rr_arb #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         req_i,
   input  logic [$clog2(NCH)-1:0] last_i,
   output logic [NCH-1:0]         gnt_o
);

   // Walk from the farthest candidate to the nearest so the nearest requester wins.
   always_comb begin
      int idx;
      gnt_o = '0;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(last_i) + k) % NCH;
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/usb_ccw_arb_ctrl.sv
// ============================================================
// usb_ccw_arb_ctrl : per-channel pending-CCW counters with round-robin
//                    read arbitration, ack timeout and sticky errors
// Rev 1.0
// ============================================================
`default_nettype none

module usb_ccw_arb_ctrl
   import usb_ccw_pkg::*;
#(
   parameter int NCH    = DEF_NCH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TO_CYC = DEF_TO_CYC
) (
   input  logic                   clk_prj,
   input  logic                   n_rst,
   input  logic [NCH-1:0]         ccw_accepted,
   input  logic [NCH-1:0]         ccw_repeat_req,
   input  logic [NCH-1:0]         ccwb_is_read,
   input  logic                   ccw_rx_rdy,
   input  logic                   err_clr,
   output logic [NCH-1:0]         ccwb_rdreq,
   output logic [$clog2(NCH)-1:0] ccw_ch_sel,
   output logic                   ccw_tx_rdy,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [NCH-1:0]         ovf_err
);

   localparam int SW    = $clog2(NCH);
   localparam int TW    = $clog2(TO_CYC + 1);
   localparam int SUM_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic           rx_s1_q, rx_s2_q, rx_s3_q;
   logic           rx_evt;
   logic [1:0]     state_q, state_d;
   logic [SW-1:0]  ch_sel_q, ch_sel_d;
   logic [SW-1:0]  last_q, last_d;
   logic           evt_pend_q, evt_pend_d;
   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic           timeout_err_q, timeout_err_d;
   logic           to_set;
   logic           ack;
   logic [NCH-1:0] req, gnt, dec;
   logic [SW-1:0]  win_idx;
   logic [CNT_W-1:0] cnt_vec [NCH];

   always_ff @(posedge clk_prj or negedge n_rst) begin
      if (!n_rst) begin
         rx_s1_q <= 1'b0;
         rx_s2_q <= 1'b0;
         rx_s3_q <= 1'b0;
      end else begin
         rx_s1_q <= ccw_rx_rdy;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   assign rx_evt = rx_s2_q & ~rx_s3_q;
   assign ack    = (state_q == ST_WAIT_RD) && ccwb_is_read[ch_sel_q];

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [SUM_W-1:0] sum;
      logic             ovf_q, ovf_d, ovf_set;

      // Decrement only when non-zero, so the net sum never goes negative.
      assign dec[g]     = ack && (ch_sel_q == SW'(g)) && (cnt_q != '0);
      assign req[g]     = (cnt_q != '0);
      assign ovf_err[g] = ovf_q;
      assign cnt_vec[g] = cnt_q;

      always_comb begin
         sum     = SUM_W'(cnt_q) + SUM_W'(ccw_accepted[g]) + SUM_W'(ccw_repeat_req[g])
                   - SUM_W'(dec[g]);
         ovf_set = (sum > SUM_W'(CNT_MAX));
         cnt_d   = ovf_set ? CNT_MAX : sum[CNT_W-1:0];
         ovf_d   = ovf_set | (ovf_q & ~err_clr);
      end

      always_ff @(posedge clk_prj or negedge n_rst) begin
         if (!n_rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end
   end

   usb_rr_arb #(
      .NCH (NCH)
   ) u_arb (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i]) win_idx = SW'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      ch_sel_d   = ch_sel_q;
      last_d     = last_q;
      evt_pend_d = evt_pend_q;
      to_cnt_d   = to_cnt_q;
      to_set     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((rx_evt || evt_pend_q) && (|req)) begin
               state_d    = ST_GRANT;
               ch_sel_d   = win_idx;
               evt_pend_d = 1'b0;
            end
         end
         ST_GRANT: begin
            state_d  = ST_WAIT_RD;
            to_cnt_d = '0;
         end
         ST_WAIT_RD: begin
            if (ack) begin
               state_d = ST_IDLE;
               last_d  = ch_sel_q;
            end else if (to_cnt_q == TW'(TO_CYC - 1)) begin
               state_d = ST_IDLE;
               to_set  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Events seen while busy are remembered once; extras are dropped.
      if (rx_evt && (state_q != ST_IDLE)) evt_pend_d = 1'b1;
      timeout_err_d = to_set | (timeout_err_q & ~err_clr);
   end

   always_ff @(posedge clk_prj or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= ST_IDLE;
         ch_sel_q      <= '0;
         last_q        <= SW'(NCH - 1);
         evt_pend_q    <= 1'b0;
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_sel_q      <= ch_sel_d;
         last_q        <= last_d;
         evt_pend_q    <= evt_pend_d;
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      ccwb_rdreq = '0;
      if (state_q == ST_GRANT) ccwb_rdreq[ch_sel_q] = 1'b1;
   end

   assign ccw_ch_sel  = ch_sel_q;
   assign busy        = (state_q != ST_IDLE);
   assign ccw_tx_rdy  = (|req) | rx_s2_q;
   assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_ccw_arb_ctrl.sv
// ============================================================
// tb_usb_ccw_arb_ctrl : directed scoreboard bench for usb_ccw_arb_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_usb_ccw_arb_ctrl;

   localparam int NCH = 4;

   logic           clk_prj        = 1'b0;
   logic           n_rst          = 1'b0;
   logic [NCH-1:0] ccw_accepted   = '0;
   logic [NCH-1:0] ccw_repeat_req = '0;
   logic [NCH-1:0] ccwb_is_read   = '0;
   logic           ccw_rx_rdy     = 1'b0;
   logic           err_clr        = 1'b0;
   logic [NCH-1:0] ccwb_rdreq;
   logic [1:0]     ccw_ch_sel;
   logic           ccw_tx_rdy;
   logic           busy;
   logic           timeout_err;
   logic [NCH-1:0] ovf_err;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_q[$];

   usb_ccw_arb_ctrl #(.NCH(NCH), .CNT_W(4), .TO_CYC(255)) dut (
      .clk_prj        (clk_prj),
      .n_rst          (n_rst),
      .ccw_accepted   (ccw_accepted),
      .ccw_repeat_req (ccw_repeat_req),
      .ccwb_is_read   (ccwb_is_read),
      .ccw_rx_rdy     (ccw_rx_rdy),
      .err_clr        (err_clr),
      .ccwb_rdreq     (ccwb_rdreq),
      .ccw_ch_sel     (ccw_ch_sel),
      .ccw_tx_rdy     (ccw_tx_rdy),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .ovf_err        (ovf_err)
   );

   always #5 clk_prj = ~clk_prj;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_prj);
   endtask

   task automatic pulse(input logic [NCH-1:0] acc, input logic [NCH-1:0] rep,
                        input logic [NCH-1:0] rd);
      ccw_accepted   = acc;
      ccw_repeat_req = rep;
      ccwb_is_read   = rd;
      tick();
      ccw_accepted   = '0;
      ccw_repeat_req = '0;
      ccwb_is_read   = '0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick(2);
      n_rst = 1'b1;
      tick();
   endtask

   task automatic check_grant(input string tag);
      int e;
      chk({tag, "_sb_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rdreq"}, ccwb_rdreq, 32'(1) << e);
         chk({tag, "_ch_sel"}, ccw_ch_sel, e);
      end
   endtask

   // Raise rx_rdy and look at the third cycle, where the grant is due.
   task automatic rx_edge_check(input string tag);
      ccw_rx_rdy = 1'b1;
      tick(3);
      check_grant(tag);
      ccw_rx_rdy = 1'b0;
   endtask

   task automatic wait_grant(input string tag);
      int found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         if (ccwb_rdreq != '0) found = 1;
         else tick();
      end
      chk({tag, "_seen"}, found, 1);
      if (found != 0) check_grant(tag);
   endtask

   task automatic ack(input int ch);
      tick();
      pulse('0, '0, NCH'(1) << ch);
   endtask

   initial begin
      int n;
      // reset state
      tick();
      chk("rst_rdreq", ccwb_rdreq, 0);
      chk("rst_ch_sel", ccw_ch_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_ovf", ovf_err, 0);
      chk("rst_tx_rdy", ccw_tx_rdy, 0);
      n_rst = 1'b1;
      tick();

      // single channel grant and acknowledge
      pulse(4'b0010, '0, '0);
      pulse(4'b0010, '0, '0);
      chk("c1_cnt2", dut.cnt_vec[1], 2);
      chk("c1_tx_rdy", ccw_tx_rdy, 1);
      exp_q.push_back(1);
      rx_edge_check("c1_grant");
      tick();
      pulse('0, '0, 4'b0100);
      chk("c1_foreign_rd_busy", busy, 1);
      ack(1);
      chk("c1_cnt_after", dut.cnt_vec[1], 1);
      chk("c1_idle", busy, 0);

      // round robin over four channels, then a discarded edge
      do_reset();
      chk("rr_cnt_cleared", dut.cnt_vec[1], 0);
      pulse(4'b1111, '0, '0);
      for (int k = 0; k < NCH; k++) begin
         exp_q.push_back(k);
         rx_edge_check($sformatf("rr_grant%0d", k));
         ack(k);
         tick(3);
      end
      chk("rr_cnt3", dut.cnt_vec[3], 0);
      ccw_rx_rdy = 1'b1;
      tick(3);
      chk("rr_fifth_rdreq", ccwb_rdreq, 0);
      chk("rr_fifth_busy", busy, 0);
      ccw_rx_rdy = 1'b0;
      tick(3);

      // acknowledge timeout
      do_reset();
      pulse(4'b0100, '0, '0);
      exp_q.push_back(2);
      rx_edge_check("to_grant");
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 256);
      chk("to_err", timeout_err, 1);
      chk("to_cnt_kept", dut.cnt_vec[2], 1);
      chk("to_busy", busy, 0);
      pulse('0, '0, '0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_clr", timeout_err, 0);

      // counter saturation
      do_reset();
      for (int k = 0; k < 15; k++) pulse(4'b0001, '0, '0);
      chk("ovf_at15_flag", ovf_err, 0);
      pulse(4'b0001, '0, '0);
      chk("ovf_cnt", dut.cnt_vec[0], 15);
      chk("ovf_flag", ovf_err, 4'b0001);
      exp_q.push_back(0);
      rx_edge_check("ovf_grant");
      tick();
      pulse(4'b0001, '0, 4'b0001);
      chk("ovf_net_cnt", dut.cnt_vec[0], 15);
      chk("ovf_net_idle", busy, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ovf_clr", ovf_err, 0);

      // two events while waiting yield exactly one further grant
      do_reset();
      pulse(4'b0111, '0, '0);
      exp_q.push_back(0);
      rx_edge_check("pend_grant0");
      tick(3);
      for (int k = 0; k < 2; k++) begin
         ccw_rx_rdy = 1'b1;
         tick(4);
         ccw_rx_rdy = 1'b0;
         tick(4);
      end
      chk("pend_still_busy", busy, 1);
      exp_q.push_back(1);
      ack(0);
      wait_grant("pend_grant1");
      ack(1);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (ccwb_rdreq != '0 || busy) n++;
         tick();
      end
      chk("pend_no_extra", n, 0);
      chk("pend_cnt2", dut.cnt_vec[2], 1);

      // reset in WAIT_RD
      do_reset();
      pulse(4'b0011, '0, '0);
      exp_q.push_back(0);
      rx_edge_check("mr_grant0");
      ack(0);
      tick(3);
      exp_q.push_back(1);
      rx_edge_check("mr_grant1");
      tick();
      chk("mr_in_wait", busy, 1);
      n_rst = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_rdreq", ccwb_rdreq, 0);
      chk("mr_ch_sel", ccw_ch_sel, 0);
      chk("mr_tx_rdy", ccw_tx_rdy, 0);
      chk("mr_cnt1", dut.cnt_vec[1], 0);
      tick();
      n_rst = 1'b1;
      tick();
      pulse(4'b0011, '0, '0);
      exp_q.push_back(0);
      rx_edge_check("mr_restart");
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
